// File: rtl/udc_pkg.sv
// udc_pkg: shared definitions for the up/down-counter host sequencer.
//   - counter register addresses on the a1:a0 bus
//   - fail cause codes reported on fail_code
//   - sequencer state enum
//   - udc_reg_sel: maps a register address to the latched job field
package udc_pkg;

  localparam logic [1:0] ADDR_PLR = 2'd0;
  localparam logic [1:0] ADDR_ULR = 2'd1;
  localparam logic [1:0] ADDR_LLR = 2'd2;
  localparam logic [1:0] ADDR_CCR = 2'd3;

  localparam logic [2:0] FAIL_NONE     = 3'd0;
  localparam logic [2:0] FAIL_LIMITS   = 3'd1;
  localparam logic [2:0] FAIL_ERR      = 3'd2;
  localparam logic [2:0] FAIL_TIMEOUT  = 3'd3;
  localparam logic [2:0] FAIL_READBACK = 3'd4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CHK,
    ST_WR0,
    ST_WR1,
    ST_WR2,
    ST_WR3,
    ST_RD0,
    ST_RD1,
    ST_RD2,
    ST_RD3,
    ST_SETTLE,
    ST_START,
    ST_RUN
  } udc_state_e;

  function automatic logic [7:0] udc_reg_sel(input logic [1:0] addr,
                                             input logic [7:0] plr,
                                             input logic [7:0] ulr,
                                             input logic [7:0] llr,
                                             input logic [7:0] ccr);
    logic [7:0] r;
    unique case (addr)
      ADDR_PLR: r = plr;
      ADDR_ULR: r = ulr;
      ADDR_LLR: r = llr;
      default:  r = ccr;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/udc_bus_controller_watchdog.sv
// udc_watchdog: RUN-phase timeout counter.
//   clk_i      system clock
//   reset_i    asynchronous active-high reset
//   clear_i    forces the count to zero (held while not running)
//   enable_i   advances the count by one per cycle, saturating at the limit
//   expired_o  count has reached TIMEOUT_CYCLES (never asserts when it is 0)
module udc_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (TIMEOUT_CYCLES != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/udc_bus_controller.sv
// udc_bus_controller: host-side sequencer for the 8-bit up/down counter.
// Accepts one job per valid/ready handshake, range-checks the limits,
// writes PLR/ULR/LLR/CCR over the ncs/nwr/nrd/a1:a0 bus, pulses start,
// then waits for end-of-cycle and reports done or fail with a cause code.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   job_valid/job_ready   job handshake; job_plr/ulr/llr/ccr job fields
//   ncs, nwr, nrd, a1, a0 counter bus controls (strobes active low)
//   bus_dout, bus_oe      write data and its tristate enable
//   bus_din               register readback data
//   start                 counter start pulse (START_W cycles)
//   udc_err, udc_ec       counter error / end-of-cycle inputs
//   busy, done, fail      status; done/fail are one-cycle pulses
//   fail_code             abort cause, held until the next accepted job
//
// Build option: define UDC_READBACK_EN to verify every register by
// reading it back after the write phase (fail code 4 on mismatch).
module udc_bus_controller
  import udc_pkg::*;
#(
  parameter int unsigned START_W        = 1,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       job_valid,
  output logic       job_ready,
  input  logic [7:0] job_plr,
  input  logic [7:0] job_ulr,
  input  logic [7:0] job_llr,
  input  logic [7:0] job_ccr,
  output logic       ncs,
  output logic       nwr,
  output logic       nrd,
  output logic       a1,
  output logic       a0,
  output logic [7:0] bus_dout,
  output logic       bus_oe,
  input  logic [7:0] bus_din,
  output logic       start,
  input  logic       udc_err,
  input  logic       udc_ec,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [2:0] fail_code
);

  udc_state_e state_q, state_d;
  logic [7:0] plr_q, ulr_q, llr_q, ccr_q;
  logic [2:0] code_q;
  logic       ready_q;
  logic       st_cnt_q;

  logic       accept;
  logic       wr_phase;
  logic       rd_phase;
  logic [1:0] addr;
  logic [7:0] sel_data;
  logic [2:0] cause;
  logic       start_last;
  logic       wd_expired;

  // A 1-bit counter covers both legal pulse widths.
  assign start_last = (START_W < 2) || st_cnt_q;

  udc_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (clk),
    .reset_i  (reset),
    .clear_i  (state_q != ST_RUN),
    .enable_i (state_q == ST_RUN),
    .expired_o(wd_expired)
  );

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    wr_phase = 1'b0;
    rd_phase = 1'b0;
    addr     = ADDR_PLR;
    ncs      = 1'b1;
    nwr      = 1'b1;
    nrd      = 1'b1;
    bus_oe   = 1'b0;
    bus_dout = '0;
    start    = 1'b0;
    done     = 1'b0;
    fail     = 1'b0;
    cause    = FAIL_NONE;

    unique case (state_q)
      ST_IDLE: begin
        if (job_valid && ready_q) begin
          accept  = 1'b1;
          state_d = ST_CHK;
        end
      end
      ST_CHK: begin
        if ((plr_q < llr_q) || (plr_q > ulr_q)) begin
          fail    = 1'b1;
          cause   = FAIL_LIMITS;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WR0;
        end
      end
      ST_WR0: begin wr_phase = 1'b1; addr = ADDR_PLR; state_d = ST_WR1; end
      ST_WR1: begin wr_phase = 1'b1; addr = ADDR_ULR; state_d = ST_WR2; end
      ST_WR2: begin wr_phase = 1'b1; addr = ADDR_LLR; state_d = ST_WR3; end
`ifdef UDC_READBACK_EN
      ST_WR3: begin wr_phase = 1'b1; addr = ADDR_CCR; state_d = ST_RD0; end
      ST_RD0: begin rd_phase = 1'b1; addr = ADDR_PLR; state_d = ST_RD1; end
      ST_RD1: begin rd_phase = 1'b1; addr = ADDR_ULR; state_d = ST_RD2; end
      ST_RD2: begin rd_phase = 1'b1; addr = ADDR_LLR; state_d = ST_RD3; end
      ST_RD3: begin rd_phase = 1'b1; addr = ADDR_CCR; state_d = ST_SETTLE; end
`else
      ST_WR3: begin wr_phase = 1'b1; addr = ADDR_CCR; state_d = ST_SETTLE; end
`endif
      ST_SETTLE: begin
        ncs = 1'b0;
        if (udc_err) begin
          fail    = 1'b1;
          cause   = FAIL_ERR;
          state_d = ST_IDLE;
        end else if (ccr_q == '0) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        ncs   = 1'b0;
        start = 1'b1;
        if (start_last) state_d = ST_RUN;
      end
      ST_RUN: begin
        ncs = 1'b0;
        // End-of-cycle takes priority over a simultaneous error.
        if (udc_ec) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else if (udc_err) begin
          fail    = 1'b1;
          cause   = FAIL_ERR;
          state_d = ST_IDLE;
        end else if (wd_expired) begin
          fail    = 1'b1;
          cause   = FAIL_TIMEOUT;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    sel_data = udc_reg_sel(addr, plr_q, ulr_q, llr_q, ccr_q);

    if (wr_phase) begin
      ncs      = 1'b0;
      nwr      = 1'b0;
      bus_oe   = 1'b1;
      bus_dout = sel_data;
    end

    if (rd_phase) begin
      ncs = 1'b0;
      nrd = 1'b0;
      if (bus_din != sel_data) begin
        fail    = 1'b1;
        cause   = FAIL_READBACK;
        state_d = ST_IDLE;
      end
    end
  end

`ifndef UDC_READBACK_EN
  logic din_unused;
  assign din_unused = ^bus_din;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b0;
      code_q   <= FAIL_NONE;
      st_cnt_q <= 1'b0;
      plr_q    <= '0;
      ulr_q    <= '0;
      llr_q    <= '0;
      ccr_q    <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= 1'b1;
      st_cnt_q <= (state_q == ST_START) && (state_d == ST_START);
      if (accept) begin
        plr_q  <= job_plr;
        ulr_q  <= job_ulr;
        llr_q  <= job_llr;
        ccr_q  <= job_ccr;
        code_q <= FAIL_NONE;
      end else if (fail) begin
        code_q <= cause;
      end
    end
  end

  // The cause is visible together with the fail pulse, then held.
  assign fail_code = fail ? cause : code_q;
  assign job_ready = ready_q && (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign a1        = addr[1];
  assign a0        = addr[0];

endmodule

// File: tb/tb_udc_bus_controller.sv
module tb_udc_bus_controller;

  localparam int unsigned SW = 1;
  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       job_valid, job_ready;
  logic [7:0] job_plr, job_ulr, job_llr, job_ccr;
  logic       ncs, nwr, nrd, a1, a0;
  logic [7:0] bus_dout, bus_din;
  logic       bus_oe, start, udc_err, udc_ec;
  logic       busy, done, fail;
  logic [2:0] fail_code;

  always #5 clk = ~clk;

  udc_bus_controller #(
    .START_W(SW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_plr(job_plr), .job_ulr(job_ulr), .job_llr(job_llr), .job_ccr(job_ccr),
    .ncs(ncs), .nwr(nwr), .nrd(nrd), .a1(a1), .a0(a0),
    .bus_dout(bus_dout), .bus_oe(bus_oe), .bus_din(bus_din),
    .start(start), .udc_err(udc_err), .udc_ec(udc_ec),
    .busy(busy), .done(done), .fail(fail), .fail_code(fail_code)
  );

  typedef struct packed {
    logic       ncs, nwr, nrd;
    logic [1:0] a;
    logic       oe, start, busy, done, fail, ready;
    logic [2:0] code;
    logic [7:0] dout;
  } obs_t;

  typedef struct {
    logic       err;
    logic       ec;
    logic [7:0] din;
    obs_t       o;
  } cyc_t;

  cyc_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic obs_t dut_obs();
    obs_t o;
    o.ncs = ncs; o.nwr = nwr; o.nrd = nrd; o.a = {a1, a0};
    o.oe = bus_oe; o.start = start; o.busy = busy; o.done = done;
    o.fail = fail; o.ready = job_ready; o.code = fail_code; o.dout = bus_dout;
    return o;
  endfunction

  function automatic obs_t reset_obs();
    obs_t o;
    o = '0;
    o.ncs = 1'b1; o.nwr = 1'b1; o.nrd = 1'b1;
    return o;
  endfunction

  // Inputs not sampled in a given phase carry random noise.
  function automatic cyc_t noise_cyc();
    cyc_t c;
    c.err = 1'($urandom);
    c.ec  = 1'($urandom);
    c.din = 8'($urandom);
    c.o   = reset_obs();
    return c;
  endfunction

  function automatic cyc_t idle_cyc(input logic [2:0] code);
    cyc_t c;
    c = noise_cyc();
    c.o.ready = 1'b1;
    c.o.code  = code;
    return c;
  endfunction

  function automatic cyc_t busy_cyc();
    cyc_t c;
    c = noise_cyc();
    c.o.busy = 1'b1;
    return c;
  endfunction

  // Expected per-cycle trace, starting with the cycle after the accept edge.
  function automatic void build_job(input logic [7:0] plr, input logic [7:0] ulr,
                                    input logic [7:0] llr, input logic [7:0] ccr,
                                    input bit err_settle, input int ec_at,
                                    input int err_at, input int rb_bad);
    logic [7:0] v [4];
    cyc_t c;
    logic [2:0] code;
    v[0] = plr; v[1] = ulr; v[2] = llr; v[3] = ccr;
    exp_q.delete();
    code = 3'd0;

    c = busy_cyc();
    if (plr < llr || plr > ulr) begin
      code = 3'd1; c.o.fail = 1'b1; c.o.code = code;
      exp_q.push_back(c);
      exp_q.push_back(idle_cyc(code));
      return;
    end
    exp_q.push_back(c);

    for (int i = 0; i < 4; i++) begin
      c = busy_cyc();
      c.o.ncs = 1'b0; c.o.nwr = 1'b0; c.o.oe = 1'b1;
      c.o.a = 2'(i); c.o.dout = v[i];
      exp_q.push_back(c);
    end

`ifdef UDC_READBACK_EN
    for (int i = 0; i < 4; i++) begin
      c = busy_cyc();
      c.o.ncs = 1'b0; c.o.nrd = 1'b0; c.o.a = 2'(i);
      c.din = (i == rb_bad) ? (v[i] ^ 8'h05) : v[i];
      if (i == rb_bad) begin
        code = 3'd4; c.o.fail = 1'b1; c.o.code = code;
        exp_q.push_back(c);
        exp_q.push_back(idle_cyc(code));
        return;
      end
      exp_q.push_back(c);
    end
    c = busy_cyc();
`else
    c = busy_cyc();
    // Corrupt readback data on the bus is irrelevant without the feature.
    if (rb_bad >= 0) c.din = v[3] ^ 8'h05;
`endif

    c.o.ncs = 1'b0;
    c.err = err_settle;
    if (err_settle) begin
      code = 3'd2; c.o.fail = 1'b1; c.o.code = code;
      exp_q.push_back(c);
      exp_q.push_back(idle_cyc(code));
      return;
    end
    if (ccr == 8'd0) begin
      c.o.done = 1'b1;
      exp_q.push_back(c);
      exp_q.push_back(idle_cyc(code));
      return;
    end
    exp_q.push_back(c);

    for (int i = 0; i < int'(SW); i++) begin
      c = busy_cyc();
      c.o.ncs = 1'b0; c.o.start = 1'b1;
      exp_q.push_back(c);
    end

    for (int j = 0; j <= int'(TO); j++) begin
      c = busy_cyc();
      c.o.ncs = 1'b0;
      c.ec  = (j == ec_at);
      c.err = (j == err_at);
      if (c.ec) begin
        c.o.done = 1'b1;
      end else if (c.err) begin
        code = 3'd2; c.o.fail = 1'b1; c.o.code = code;
      end else if (j == int'(TO)) begin
        code = 3'd3; c.o.fail = 1'b1; c.o.code = code;
      end
      exp_q.push_back(c);
      if (c.o.done || c.o.fail) break;
    end
    exp_q.push_back(idle_cyc(code));
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (job_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready", 32'(job_ready), 32'd1);
  endtask

  task automatic run_job(input logic [7:0] plr, input logic [7:0] ulr,
                         input logic [7:0] llr, input logic [7:0] ccr,
                         input bit err_settle, input int ec_at,
                         input int err_at, input int rb_bad);
    build_job(plr, ulr, llr, ccr, err_settle, ec_at, err_at, rb_bad);
    wait_ready();
    job_valid = 1'b1;
    job_plr = plr; job_ulr = ulr; job_llr = llr; job_ccr = ccr;
    @(posedge clk); #1;
    foreach (exp_q[k]) begin
      // Random valid and fields while busy: must be ignored.
      job_valid = (k == exp_q.size() - 1) ? 1'b0 : 1'($urandom);
      job_plr = 8'($urandom); job_ulr = 8'($urandom);
      job_llr = 8'($urandom); job_ccr = 8'($urandom);
      udc_err = exp_q[k].err;
      udc_ec  = exp_q[k].ec;
      bus_din = exp_q[k].din;
      @(negedge clk);
      check($sformatf("cyc%0d", k), 32'(dut_obs()), 32'(exp_q[k].o));
      @(posedge clk); #1;
    end
    job_valid = 1'b0;
  endtask

  task automatic reset_mid_job();
    wait_ready();
    job_valid = 1'b1;
    job_plr = 8'd10; job_ulr = 8'd20; job_llr = 8'd5; job_ccr = 8'd3;
    udc_err = 1'b0; udc_ec = 1'b0;
    @(posedge clk); #1;
    job_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("wr2_bus", 32'({ncs, nwr, a1, a0, bus_dout}), 32'({4'b0010, 8'd5}));
    reset = 1'b1;
    #1;
    check("rst_async", 32'(dut_obs()), 32'(reset_obs()));
    @(posedge clk); #2;
    check("rst_hold", 32'(dut_obs()), 32'(reset_obs()));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_rel_ready", 32'(job_ready), 32'd0);
    @(posedge clk); #1;
    check("rst_ready_rise", 32'(job_ready), 32'd1);
    run_job(8'd1, 8'd255, 8'd0, 8'd1, 1'b0, 2, -1, -1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [7:0] x, y, z, t, ccr;
    reset = 1'b1;
    job_valid = 1'b0;
    job_plr = '0; job_ulr = '0; job_llr = '0; job_ccr = '0;
    udc_err = 1'b0; udc_ec = 1'b0; bus_din = '0;

    @(posedge clk); #2;
    check("por", 32'(dut_obs()), 32'(reset_obs()));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("por_ready_low", 32'(job_ready), 32'd0);
    @(posedge clk); #1;
    check("por_ready_rise", 32'(job_ready), 32'd1);

    run_job(8'd0, 8'd5, 8'd0, 8'd2, 1'b0, 10, -1, -1);     // normal, done
    run_job(8'd3, 8'd5, 8'd4, 8'h11, 1'b0, 5, -1, -1);     // plr < llr
    run_job(8'd9, 8'd8, 8'd0, 8'h11, 1'b0, 5, -1, -1);     // plr > ulr
    run_job(8'd2, 8'd9, 8'd1, 8'd0, 1'b0, -1, -1, -1);     // ccr = 0
    run_job(8'd4, 8'd4, 8'd4, 8'd9, 1'b0, -1, -1, -1);     // limits equal, timeout
    run_job(8'd7, 8'd8, 8'd6, 8'd5, 1'b1, -1, -1, -1);     // err at settle
    run_job(8'd5, 8'd200, 8'd3, 8'd9, 1'b0, 4, 2, -1);     // err during run
    run_job(8'd5, 8'd200, 8'd3, 8'd9, 1'b0, 3, 3, -1);     // ec and err together
    run_job(8'd0, 8'd5, 8'd0, 8'd2, 1'b0, 6, -1, 3);       // CCR readback 0x07
    run_job(8'd0, 8'd255, 8'd0, 8'd255, 1'b0, int'(TO) - 1, -1, -1);

    reset_mid_job();

    for (int n = 0; n < 40; n++) begin
      x = 8'($urandom); y = 8'($urandom); z = 8'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (x > y) begin t = x; x = y; y = t; end
        if (y > z) begin t = y; y = z; z = t; end
        if (x > y) begin t = x; x = y; y = t; end
        // x <= y <= z : llr, plr, ulr
        t = x; x = y; y = z; z = t;
      end
      ccr = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
      run_job(x, y, z, ccr,
              ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 20)),
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 20)) : -1,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
